// File: rtl/misr_response_checker.sv
// Multiple-input signature register that compacts DUT response words
// and compares the final signature against a golden value.
module misr_response_checker #(
    parameter int                W        = 8,
    parameter int                N_CYCLES = 255,
    parameter logic [W-1:0]      POLY     = 8'h1D,
    parameter logic [W-1:0]      SEED     = 8'h00,
    localparam int               CW       = $clog2(N_CYCLES + 1)
) (
    input  logic          C,
    input  logic          RN,
    input  logic          START,
    input  logic          EN,
    input  logic [W-1:0]  D,
    input  logic [W-1:0]  GOLDEN,
    output logic          BUSY,
    output logic          DONE,
    output logic          PASS,
    output logic [W-1:0]  SIG,
    output logic [CW-1:0] CNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  sig_nx;
    logic [W-1:0]  step;
    logic [CW-1:0] cnt_nx;
    logic          busy_nx, done_nx, pass_nx;
    logic          last;

    // Galois left-shift step with the new response word folded in.
    assign step = (SIG << 1) ^ (SIG[W-1] ? POLY : '0) ^ D;
    assign last = (CNT == CW'(N_CYCLES - 1));

    always_comb begin
        state_nx = state;
        sig_nx   = SIG;
        cnt_nx   = CNT;
        busy_nx  = BUSY;
        done_nx  = DONE;
        pass_nx  = PASS;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_nx = S_RUN;
                    sig_nx   = SEED;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                    done_nx  = 1'b0;
                    pass_nx  = 1'b0;
                end
            end
            S_RUN: begin
                if (EN) begin
                    sig_nx = step;
                    cnt_nx = CNT + CW'(1);
                    if (last) begin
                        state_nx = S_DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        pass_nx  = (step == GOLDEN);
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                busy_nx  = 1'b0;
                done_nx  = 1'b0;
                pass_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state <= S_IDLE;
            SIG   <= '0;
            CNT   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            PASS  <= 1'b0;
        end else begin
            state <= state_nx;
            SIG   <= sig_nx;
            CNT   <= cnt_nx;
            BUSY  <= busy_nx;
            DONE  <= done_nx;
            PASS  <= pass_nx;
        end
    end

endmodule

// File: tb/tb_misr_response_checker.sv
// Scoreboard bench for misr_response_checker: three instances
// (N_CYCLES = 1, 2, 255) checked against a behavioural signature model.
module tb_misr_response_checker;

    logic       C = 1'b0;
    logic       RN = 1'b0;
    logic       start [3];
    logic       en    [3];
    logic [7:0] d     [3];
    logic [7:0] g     [3];
    logic       busy  [3];
    logic       done  [3];
    logic       pass  [3];
    logic [7:0] sig   [3];
    logic [0:0] cnt0;
    logic [1:0] cnt1;
    logic [7:0] cnt2;
    logic       done_q [3];

    typedef struct {
        logic [7:0] s;
        logic       p;
    } exp_t;

    exp_t sb [3][$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 C = ~C;

    misr_response_checker #(.W(8), .N_CYCLES(1)) u_n1 (
        .C(C), .RN(RN), .START(start[0]), .EN(en[0]), .D(d[0]),
        .GOLDEN(g[0]), .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]),
        .SIG(sig[0]), .CNT(cnt0)
    );

    misr_response_checker #(.W(8), .N_CYCLES(2)) u_n2 (
        .C(C), .RN(RN), .START(start[1]), .EN(en[1]), .D(d[1]),
        .GOLDEN(g[1]), .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]),
        .SIG(sig[1]), .CNT(cnt1)
    );

    misr_response_checker u_def (
        .C(C), .RN(RN), .START(start[2]), .EN(en[2]), .D(d[2]),
        .GOLDEN(g[2]), .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]),
        .SIG(sig[2]), .CNT(cnt2)
    );

    // Signature as polynomial arithmetic: multiply by x modulo
    // x^8 + 0x1D, then add the sample.
    function automatic logic [7:0] ref_sig(input logic [7:0] seed,
                                           input logic [7:0] q[$]);
        int s;
        s = int'(seed);
        foreach (q[i]) begin
            s = s * 2;
            if (s >= 256) s = (s - 256) ^ 'h1D;
            s = s ^ int'(q[i]);
        end
        return s[7:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic sample(input int k, input logic [7:0] v);
        en[k] = 1'b1;
        d[k]  = v;
        tick();
        en[k] = 1'b0;
    endtask

    always @(negedge C) begin
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ((busy[k] && done[k]) || (pass[k] && !done[k])) begin
                n_fail++;
                $display("FAIL invariant[%0d]: busy=%b done=%b pass=%b",
                         k, busy[k], done[k], pass[k]);
            end
            if (done[k] && !done_q[k]) begin
                if (sb[k].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done[%0d]: sig=%0h", k, sig[k]);
                end else begin
                    exp_t e;
                    e = sb[k].pop_front();
                    chk($sformatf("sb_sig[%0d]", k), 32'(sig[k]), 32'(e.s));
                    chk($sformatf("sb_pass[%0d]", k), 32'(pass[k]), 32'(e.p));
                end
            end
            done_q[k] = done[k];
        end
    end

    task automatic run_def(input bit flip);
        logic [7:0] q[$];
        logic [7:0] qf[$];
        logic [7:0] gold;
        int         idx;
        for (int i = 0; i < 255; i++) q.push_back(8'($urandom));
        qf   = q;
        gold = ref_sig(8'h00, q);
        if (flip) begin
            idx     = $urandom_range(0, 254);
            qf[idx] = qf[idx] ^ (8'h01 << $urandom_range(0, 7));
        end
        sb[2].push_back('{ref_sig(8'h00, qf), ref_sig(8'h00, qf) == gold});
        g[2] = gold;
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        foreach (qf[i]) begin
            if ($urandom_range(0, 3) == 0) tick();
            sample(2, qf[i]);
        end
        chk("def_done", 32'(done[2]), 32'd1);
        chk("def_cnt", 32'(cnt2), 32'd255);
        chk("def_pass", 32'(pass[2]), 32'(!flip));
    endtask

    initial begin
        logic [7:0] q2[$];
        logic [7:0] gr;
        for (int k = 0; k < 3; k++) begin
            start[k]  = 1'b0;
            en[k]     = 1'b0;
            d[k]      = 8'h00;
            g[k]      = 8'h00;
            done_q[k] = 1'b0;
        end
        RN = 1'b0;
        repeat (2) tick();
        chk("rst_busy", 32'(busy[2]), 32'd0);
        chk("rst_done", 32'(done[2]), 32'd0);
        chk("rst_pass", 32'(pass[2]), 32'd0);
        chk("rst_sig", 32'(sig[2]), 32'd0);
        chk("rst_cnt", 32'(cnt2), 32'd0);
        RN = 1'b1;
        tick();

        // START with EN in IDLE: that sample must be dropped
        start[0] = 1'b1;
        en[0]    = 1'b1;
        d[0]     = 8'hFF;
        tick();
        start[0] = 1'b0;
        en[0]    = 1'b0;
        chk("n1_busy", 32'(busy[0]), 32'd1);
        chk("n1_cnt0", 32'(cnt0), 32'd0);
        chk("n1_seed", 32'(sig[0]), 32'h00);
        g[0] = 8'h5A;
        sb[0].push_back('{8'h5A, 1'b1});
        sample(0, 8'h5A);
        chk("n1_done", 32'(done[0]), 32'd1);
        chk("n1_pass", 32'(pass[0]), 32'd1);
        chk("n1_sig", 32'(sig[0]), 32'h5A);
        chk("n1_cnt", 32'(cnt0), 32'd1);

        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        sample(1, 8'h80);
        chk("n2_sig1", 32'(sig[1]), 32'h80);
        chk("n2_cnt1", 32'(cnt1), 32'd1);
        chk("n2_nodone", 32'(done[1]), 32'd0);
        g[1] = 8'h1D;
        sb[1].push_back('{8'h1D, 1'b1});
        sample(1, 8'h00);
        chk("n2_done", 32'(done[1]), 32'd1);
        chk("n2_pass", 32'(pass[1]), 32'd1);
        chk("n2_sig2", 32'(sig[1]), 32'h1D);

        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        chk("restart_done", 32'(done[1]), 32'd0);
        chk("restart_pass", 32'(pass[1]), 32'd0);
        chk("restart_sig", 32'(sig[1]), 32'h00);
        chk("restart_cnt", 32'(cnt1), 32'd0);
        sample(1, 8'h80);
        for (int i = 0; i < 4; i++) begin
            start[1] = (i == 1);
            tick();
            start[1] = 1'b0;
            chk("gap_done", 32'(done[1]), 32'd0);
            chk("gap_cnt", 32'(cnt1), 32'd1);
            chk("gap_busy", 32'(busy[1]), 32'd1);
        end
        g[1] = 8'h1C;
        sb[1].push_back('{8'h1D, 1'b0});
        start[1] = 1'b1;
        sample(1, 8'h00);
        start[1] = 1'b0;
        chk("gap_done_edge", 32'(done[1]), 32'd1);
        chk("gap_fail", 32'(pass[1]), 32'd0);
        chk("gap_sig", 32'(sig[1]), 32'h1D);
        chk("gap_cnt2", 32'(cnt1), 32'd2);
        tick();
        chk("done_hold", 32'(done[1]), 32'd1);

        // asynchronous abort mid-run, between clock edges
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        for (int i = 0; i < 3; i++) sample(2, 8'($urandom));
        chk("abort_cnt", 32'(cnt2), 32'd3);
        #2;
        RN = 1'b0;
        #1;
        chk("abort_busy", 32'(busy[2]), 32'd0);
        chk("abort_sig", 32'(sig[2]), 32'd0);
        chk("abort_cnt0", 32'(cnt2), 32'd0);
        chk("abort_done_n2", 32'(done[1]), 32'd0);
        #2;
        RN = 1'b1;
        repeat (10) tick();
        chk("idle_busy", 32'(busy[2]), 32'd0);
        chk("idle_done", 32'(done[2]), 32'd0);

        for (int r = 0; r < 6; r++) begin
            q2.delete();
            q2.push_back(8'($urandom));
            q2.push_back(8'($urandom));
            gr   = ref_sig(8'h00, q2);
            g[1] = (r % 2 == 0) ? gr : 8'(gr ^ 8'(1 << (r % 8)));
            sb[1].push_back('{gr, g[1] == gr});
            start[1] = 1'b1;
            tick();
            start[1] = 1'b0;
            sample(1, q2[0]);
            repeat ($urandom_range(0, 3)) tick();
            sample(1, q2[1]);
        end

        run_def(1'b0);
        run_def(1'b1);
        tick();
        for (int k = 0; k < 3; k++)
            chk($sformatf("sb_empty[%0d]", k), 32'(sb[k].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
